// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- multi-ported register file with load scoreboard
//
// Register file for a multicycle AHB-bus ARM core. Two combinational read
// ports, an ALU write port with byte enables, and a load-return write port for
// bus data phases that complete late. A per-register busy bit tracks loads
// that have been issued but not yet returned, so control can stall on them.
// The PC index is never stored: reads of it return the externally supplied
// pc_in (PC+8) and writes or reservations of it are dropped.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ra1/ra2 -> rd1/rd2  combinational read ports (optionally bypassed)
//   busy1/busy2         operand has an outstanding load
//   pc_in               value returned for reads of PC_IDX
//   we3/wa3/wd3/be3     ALU write port, byte-enabled
//   weL/waL/wdL         load-return write port, full word, clears busy
//   rsv_en/rsv_addr     mark a register busy (load issued)
//   busy_vec            registered scoreboard state
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS),
    parameter int PC_IDX = NREGS - 1,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    output logic               busy1,
    output logic               busy2,
    input  logic [WIDTH-1:0]   pc_in,
    input  logic               we3,
    input  logic [AW-1:0]      wa3,
    input  logic [WIDTH-1:0]   wd3,
    input  logic [WIDTH/8-1:0] be3,
    input  logic               weL,
    input  logic [AW-1:0]      waL,
    input  logic [WIDTH-1:0]   wdL,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic [NREGS-1:0]   busy_vec
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next-state of every register and busy bit. The assignments are layered
    // so later ones override earlier ones: load data first, then ALU bytes on
    // top (ALU wins per enabled byte), and for busy the load clear first, then
    // the reservation (reserve wins for back-to-back loads).
    // NOTE: blocking assignments in always_comb, with the hold value assigned
    // first, give priority by statement order and can never infer a latch.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            busy_d[r] = busy_q[r];
            if (r != PC_IDX) begin
                if (weL && (waL == AW'(r))) begin
                    regs_d[r] = wdL;
                    busy_d[r] = 1'b0;
                end
                if (we3 && (wa3 == AW'(r))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be3[b]) begin
                            regs_d[r][8*b +: 8] = wd3[8*b +: 8];
                        end
                    end
                end
                if (rsv_en && (rsv_addr == AW'(r))) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
    end

    // Read port 1. regs_d equals regs_q for registers not written this cycle,
    // so reading regs_d is exactly the same-cycle forwarding rule. A load
    // returning to the register being read releases the stall immediately.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (int'(ra1) == PC_IDX) begin
            rd1 = pc_in;
        end else if (int'(ra1) < NREGS) begin
            rd1   = (BYPASS != 0) ? regs_d[ra1] : regs_q[ra1];
            busy1 = busy_q[ra1] & ~(weL && (waL == ra1));
        end
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (int'(ra2) == PC_IDX) begin
            rd2 = pc_in;
        end else if (int'(ra2) < NREGS) begin
            rd2   = (BYPASS != 0) ? regs_d[ra2] : regs_q[ra2];
            busy2 = busy_q[ra2] & ~(weL && (waL == ra2));
        end
    end

    // NOTE: the register array is reset here because architectural state must
    // read as zero after reset; a plain storage RAM would normally not be.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb (default parameters)
//
// Inputs change 1 time unit after each rising edge; combinational outputs and
// busy_vec are sampled on the falling edge, before the state update.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int WIDTH  = 32;
    localparam int NREGS  = 16;
    localparam int AW     = 4;
    localparam int PC_IDX = 15;

    logic              clk;
    logic              reset;
    logic [AW-1:0]     ra1, ra2;
    logic [WIDTH-1:0]  rd1, rd2;
    logic              busy1, busy2;
    logic [WIDTH-1:0]  pc_in;
    logic              we3;
    logic [AW-1:0]     wa3;
    logic [WIDTH-1:0]  wd3;
    logic [3:0]        be3;
    logic              weL;
    logic [AW-1:0]     waL;
    logic [WIDTH-1:0]  wdL;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NREGS-1:0]  busy_vec;

    regfile_sb #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW),
        .PC_IDX(PC_IDX),
        .BYPASS(1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .busy1   (busy1),
        .busy2   (busy2),
        .pc_in   (pc_in),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .be3     (be3),
        .weL     (weL),
        .waL     (waL),
        .wdL     (wdL),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle of stimulus plus the outputs expected before its clock edge.
    typedef struct {
        logic        rst;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] pc;
        logic        we3;
        logic [3:0]  wa3;
        logic [31:0] wd3;
        logic [3:0]  be3;
        logic        wel;
        logic [3:0]  wal;
        logic [31:0] wdl;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [15:0] e_bv;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    task automatic drive(input vec_t v);
        reset    = v.rst;
        ra1      = v.ra1;
        ra2      = v.ra2;
        pc_in    = v.pc;
        we3      = v.we3;
        wa3      = v.wa3;
        wd3      = v.wd3;
        be3      = v.be3;
        weL      = v.wel;
        waL      = v.wal;
        wdL      = v.wdl;
        rsv_en   = v.rsv_en;
        rsv_addr = v.rsv_addr;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; ra1 = '0; ra2 = '0; pc_in = 32'h0000_1008;
        we3 = 1'b0; wa3 = '0; wd3 = '0; be3 = '0;
        weL = 1'b0; waL = '0; wdL = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_regs [NREGS];
    logic [15:0] m_busy;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // Value register r holds after this cycle's edge (ignoring reset).
    function automatic logic [31:0] m_next(input int r);
        logic [31:0] v = m_regs[r];
        logic [31:0] m;
        if (r == PC_IDX) return v;
        if (weL && int'(waL) == r) v = wdL;
        if (we3 && int'(wa3) == r) begin
            m = byte_mask(be3);
            v = (v & ~m) | (wd3 & m);
        end
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] ra);
        if (int'(ra) == PC_IDX) return pc_in;
        return m_next(int'(ra));
    endfunction

    function automatic logic m_busy_rd(input logic [3:0] ra);
        if (int'(ra) == PC_IDX) return 1'b0;
        return m_busy[ra] && !(weL && waL == ra);
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_busy = '0;
    endtask

    // Advance the model across the coming edge using the current inputs.
    task automatic m_update();
        logic [31:0] nxt [NREGS];
        if (reset) begin
            m_clear();
        end else begin
            for (int r = 0; r < NREGS; r++) nxt[r] = m_next(r);
            for (int r = 0; r < NREGS; r++) m_regs[r] = nxt[r];
            if (weL && int'(waL) != PC_IDX) m_busy[waL] = 1'b0;
            if (rsv_en && int'(rsv_addr) != PC_IDX) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 4));
    endfunction

    initial begin
        // Directed sequence: each row is one cycle.
        //            rst ra1 ra2 pc            we3 wa3 wd3            be3      wel wal wdl            rsv  addr e_rd1          e_rd2          b1 b2 bv
        tbl[0]  = '{1'b0, 3,  0, 32'h0000_1008, 1'b1, 3, 32'h1122_3344, 4'hF,    1'b0, 0, 32'h0,        1'b0, 0, 32'h1122_3344, 32'h0,         1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 3,  3, 32'h0000_1008, 1'b1, 3, 32'hAABB_CCDD, 4'b0101, 1'b0, 0, 32'h0,        1'b0, 0, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 3,  5, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b0, 0, 32'h0,        1'b1, 5, 32'h11BB_33DD, 32'h0,         1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 5,  5, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b0, 0, 32'h0,        1'b0, 0, 32'h0,         32'h0,         1'b1, 1'b1, 16'h0020};
        tbl[4]  = '{1'b0, 5,  4, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 16'h0020};
        tbl[5]  = '{1'b0, 5,  0, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b1, 5, 32'hCAFE_F00D, 1'b1, 5, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 5,  5, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b1, 5, 32'h0102_0304, 1'b0, 0, 32'h0102_0304, 32'h0102_0304, 1'b0, 1'b0, 16'h0020};
        tbl[7]  = '{1'b0, 7,  5, 32'h0000_1008, 1'b1, 7, 32'h0000_FFFF, 4'b0011, 1'b1, 7, 32'h1234_5678, 1'b0, 0, 32'h1234_FFFF, 32'h0102_0304, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 7, 15, 32'hABCD_0000, 1'b1, 15,32'hFFFF_FFFF, 4'hF,    1'b1, 15,32'h5555_5555, 1'b1, 15,32'h1234_FFFF, 32'hABCD_0000, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 15, 3, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b0, 0, 32'h0,        1'b1, 2, 32'h0000_1008, 32'h11BB_33DD, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 2,  3, 32'h0000_1008, 1'b1, 3, 32'hFFFF_FFFF, 4'h0,    1'b0, 0, 32'h0,        1'b0, 0, 32'h0,         32'h11BB_33DD, 1'b1, 1'b0, 16'h0004};
        tbl[11] = '{1'b1, 2,  3, 32'h0000_1008, 1'b1, 4, 32'hFFFF_FFFF, 4'hF,    1'b0, 0, 32'h0,        1'b1, 6, 32'h0,         32'h11BB_33DD, 1'b1, 1'b0, 16'h0004};
        tbl[12] = '{1'b0, 2,  4, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b1, 2, 32'h0000_0005, 1'b0, 0, 32'h0000_0005, 32'h0,         1'b0, 1'b0, 16'h0000};
        tbl[13] = '{1'b0, 2,  7, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b0, 0, 32'h0,        1'b0, 0, 32'h0000_0005, 32'h0,         1'b0, 1'b0, 16'h0000};
        tbl[14] = '{1'b0, 6,  3, 32'h0000_1008, 1'b0, 0, 32'h0,         4'h0,    1'b0, 0, 32'h0,        1'b0, 0, 32'h0,         32'h0,         1'b0, 1'b0, 16'h0000};

        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset state: every register reads 0, PC index reads pc_in.
        for (int i = 0; i < NREGS / 2; i++) begin
            ra1 = 4'(2 * i);
            ra2 = 4'(2 * i + 1);
            @(negedge clk);
            check($sformatf("reset_rd_r%0d", 2 * i), rd1, 32'h0);
            check($sformatf("reset_rd_r%0d", 2 * i + 1), rd2,
                  (2 * i + 1 == PC_IDX) ? 32'h0000_1008 : 32'h0);
            check("reset_busy_vec", {16'h0, busy_vec}, 32'h0);
            next_cycle();
        end

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d_rd1", i), rd1, tbl[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), rd2, tbl[i].e_rd2);
            check($sformatf("vec%0d_busy1", i), {31'h0, busy1}, {31'h0, tbl[i].e_b1});
            check($sformatf("vec%0d_busy2", i), {31'h0, busy2}, {31'h0, tbl[i].e_b2});
            check($sformatf("vec%0d_busy_vec", i), {16'h0, busy_vec}, {16'h0, tbl[i].e_bv});
            next_cycle();
        end

        // ALU write to a busy register leaves it busy (multi-cycle sequence).
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 4'd9;
        next_cycle();
        idle_inputs();
        we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h0BAD_F00D; be3 = 4'hF; ra1 = 4'd9;
        @(negedge clk);
        check("alu_busy_rd1", rd1, 32'h0BAD_F00D);
        check("alu_busy_busy1", {31'h0, busy1}, 32'h1);
        next_cycle();
        idle_inputs();
        ra1 = 4'd9;
        @(negedge clk);
        check("alu_busy_after", {31'h0, busy1}, 32'h1);
        check("alu_busy_vec", {16'h0, busy_vec}, 32'h0000_0200);

        // Randomised phase against the reference model.
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        m_clear();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            ra1      = rnd_addr();
            ra2      = rnd_addr();
            pc_in    = $urandom;
            we3      = $urandom_range(0, 1) == 1;
            wa3      = rnd_addr();
            wd3      = $urandom;
            be3      = 4'($urandom_range(0, 15));
            weL      = $urandom_range(0, 2) == 0;
            waL      = rnd_addr();
            wdL      = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = rnd_addr();
            @(negedge clk);
            check("rnd_rd1", rd1, m_read(ra1));
            check("rnd_rd2", rd2, m_read(ra2));
            check("rnd_busy1", {31'h0, busy1}, {31'h0, m_busy_rd(ra1)});
            check("rnd_busy2", {31'h0, busy2}, {31'h0, m_busy_rd(ra2)});
            check("rnd_busy_vec", {16'h0, busy_vec}, {16'h0, m_busy});
            m_update();
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
